// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared defaults and helpers for the DE2-115 slide-switch conditioner.
//   SW_WIDTH        : number of slide switches on the board
//   SW_TICK_DIV     : clk cycles per debounce sample tick (1 ms at 50 MHz)
//   SW_STABLE_TICKS : consecutive disagreeing ticks needed to flip an output
//   sw_clog2()      : counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

   localparam int SW_WIDTH        = 18;
   localparam int SW_TICK_DIV     = 50000;
   localparam int SW_STABLE_TICKS = 10;

   // Number of bits needed to hold the values 0..value-1. A one-bit floor
   // keeps degenerate parameter choices (value of 1) from producing a
   // zero-width vector.
   function automatic int sw_clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch channel: 2-FF synchronizer, tick-gated stability counter,
// registered clean level, one-cycle change pulse and an optional sticky
// rising-edge flag.
// Optional feature macro: SW_EDGE_CAPTURE_EN (edge_capture flop; when the
// macro is undefined edge_capture is tied low and edge_clear is ignored).
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   tick          : one-cycle sample strobe from the shared prescaler
//   sw_raw        : asynchronous switch pin
//   edge_clear    : clears the sticky edge flag
//   sw_clean      : debounced level
//   sw_change     : one-cycle pulse when sw_clean flips
//   edge_capture  : sticky rising-edge flag
// ---------------------------------------------------------------------------
module sw_debounce_bit
   import sw_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw_raw,
   input  logic edge_clear,
   output logic sw_clean,
   output logic sw_change,
   output logic edge_capture
);

   localparam int               CNT_W    = sw_clog2(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clean_q;
   logic             clean_d;
   logic             change_q;
   logic             change_d;

   // Stability decision, only on tick cycles. Any tick that agrees with the
   // current clean level discards the run of disagreeing ticks, so bounce
   // restarts the window. The counter is cleared on the flip itself, which
   // keeps it within 0..STABLE_TICKS-1.
   always_comb begin
      cnt_d    = cnt_q;
      clean_d  = clean_q;
      change_d = 1'b0;
      if (tick) begin
         if (sync2_q == clean_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            clean_d  = sync2_q;
            cnt_d    = '0;
            change_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer pair plus the channel state. sw_raw feeds nothing but
   // sync1_q, so only sync2_q is seen by the rest of the logic.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         clean_q  <= 1'b0;
         change_q <= 1'b0;
      end else begin
         sync1_q  <= sw_raw;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         clean_q  <= clean_d;
         change_q <= change_d;
      end
   end

   assign sw_clean  = clean_q;
   assign sw_change = change_q;

`ifdef SW_EDGE_CAPTURE_EN
   logic capture_q;
   logic capture_d;

   // Sticky rising-edge flag. Set is taken from the registered pulse, so it
   // lands one cycle after sw_change; a set in the same cycle as a clear
   // wins so an edge is never lost to a late acknowledge.
   always_comb begin
      capture_d = capture_q;
      if (edge_clear) begin
         capture_d = 1'b0;
      end
      if (change_q && clean_q) begin
         capture_d = 1'b1;
      end
   end

   // Capture flag register.
   always_ff @(posedge clk) begin
      if (reset) begin
         capture_q <= 1'b0;
      end else begin
         capture_q <= capture_d;
      end
   end

   assign edge_capture = capture_q;
`else
   logic unused_edge_clear;

   assign unused_edge_clear = edge_clear;
   assign edge_capture      = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Conditions the raw DE2-115 slide switches ahead of the switch PIO in_port.
// A shared prescaler produces the sample tick; each bit is handled by an
// independent sw_debounce_bit channel.
// Optional feature macro: SW_EDGE_CAPTURE_EN (sticky rising-edge flags).
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   sw_raw        : asynchronous switch pins
//   sw_clean      : debounced switch vector (to PIO in_port)
//   sw_change     : one-cycle per-bit pulse when sw_clean flips
//   sw_valid      : high once the first full debounce window has elapsed
//   edge_clear    : per-bit clear of edge_capture
//   edge_capture  : sticky per-bit rising-edge flags
// ---------------------------------------------------------------------------
module sw_debounce
   import sw_debounce_pkg::*;
#(
   parameter int WIDTH        = SW_WIDTH,
   parameter int TICK_DIV     = SW_TICK_DIV,
   parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_change,
   output logic             sw_valid,
   input  logic [WIDTH-1:0] edge_clear,
   output logic [WIDTH-1:0] edge_capture
);

   localparam int               PRE_W    = sw_clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam int               VLD_W    = sw_clog2(STABLE_TICKS);
   localparam logic [VLD_W-1:0] VLD_LAST = VLD_W'(STABLE_TICKS - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick;
   logic [VLD_W-1:0] vld_cnt_q;
   logic [VLD_W-1:0] vld_cnt_d;
   logic             valid_q;
   logic             valid_d;

   assign tick = (pre_q == PRE_LAST);

   // Prescaler wraps on the tick cycle. sw_valid follows the same tick
   // count as the channels, so it rises on the STABLE_TICKS-th tick, the
   // same edge on which a switch held since reset reaches sw_clean. The
   // tick counter then freezes until the next reset.
   always_comb begin
      pre_d     = tick ? '0 : pre_q + PRE_W'(1);
      vld_cnt_d = vld_cnt_q;
      valid_d   = valid_q;
      if (tick && !valid_q) begin
         if (vld_cnt_q == VLD_LAST) begin
            valid_d   = 1'b1;
            vld_cnt_d = '0;
         end else begin
            vld_cnt_d = vld_cnt_q + VLD_W'(1);
         end
      end
   end

   // Prescaler and valid-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q     <= '0;
         vld_cnt_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         pre_q     <= pre_d;
         vld_cnt_q <= vld_cnt_d;
         valid_q   <= valid_d;
      end
   end

   assign sw_valid = valid_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
         .clk          (clk),
         .reset        (reset),
         .tick         (tick),
         .sw_raw       (sw_raw[i]),
         .edge_clear   (edge_clear[i]),
         .sw_clean     (sw_clean[i]),
         .sw_change    (sw_change[i]),
         .edge_capture (edge_capture[i])
      );
   end

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
// Self-checking bench for sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
// A reference model describes each bit as "flip when the last STABLE_TICKS
// tick samples all disagree with the clean level", where a tick sample is
// the pin value two clocks earlier. Change events are queued by the model
// and popped by a monitor whenever the DUT shows a pulse or sw_valid rises.
// Follows SW_EDGE_CAPTURE_EN for the expected edge_capture behaviour.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

   localparam int W  = 18;
   localparam int TD = 4;
   localparam int ST = 3;

`ifdef SW_EDGE_CAPTURE_EN
   localparam bit CAP_EN = 1'b1;
`else
   localparam bit CAP_EN = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic [W-1:0] sw_raw;
   logic [W-1:0] sw_clean;
   logic [W-1:0] sw_change;
   logic         sw_valid;
   logic [W-1:0] edge_clear;
   logic [W-1:0] edge_capture;

   sw_debounce #(
      .WIDTH        (W),
      .TICK_DIV     (TD),
      .STABLE_TICKS (ST)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sw_raw       (sw_raw),
      .sw_clean     (sw_clean),
      .sw_change    (sw_change),
      .sw_valid     (sw_valid),
      .edge_clear   (edge_clear),
      .edge_capture (edge_capture)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int                   n;
      int                   ticks;
      logic [ST-1:0][W-1:0] hist;
      int                   nhist;
      logic [W-1:0]         clean;
      logic [W-1:0]         change;
      logic [W-1:0]         cap;
      logic                 valid;
   } mstate_t;

   typedef struct {
      int           cyc;
      logic [W-1:0] clean;
      logic [W-1:0] change;
      logic         valid;
   } exp_t;

   int           tests;
   int           fails;
   int           cycle;
   bit           armed;
   mstate_t      ms;
   exp_t         exp_q[$];
   logic [W-1:0] raw_log[$];
   int           pulse_cnt[W];
   int           full_change_cnt;

   // One clock edge of the reference behaviour. samp is the pin value the
   // DUT sees on this edge after its two-clock synchronization delay.
   function automatic mstate_t modelStep(input mstate_t s, input logic rst,
                                         input logic [W-1:0] samp,
                                         input logic [W-1:0] clr);
      mstate_t      r;
      logic [W-1:0] all_diff;
      r = s;
      if (rst) begin
         r.n      = 0;
         r.ticks  = 0;
         r.hist   = '0;
         r.nhist  = 0;
         r.clean  = '0;
         r.change = '0;
         r.cap    = '0;
         r.valid  = 1'b0;
         return r;
      end
      r.n      = s.n + 1;
      r.change = '0;
      r.cap    = CAP_EN ? ((s.cap & ~clr) | (s.change & s.clean)) : '0;
      if (r.n % TD == 0) begin
         r.ticks = s.ticks + 1;
         r.hist  = {s.hist[ST-2:0], samp};
         r.nhist = (s.nhist < ST) ? s.nhist + 1 : ST;
         if (r.nhist == ST) begin
            all_diff = '1;
            for (int k = 0; k < ST; k++) begin
               all_diff = all_diff & (r.hist[k] ^ s.clean);
            end
            r.change = all_diff;
            r.clean  = s.clean ^ all_diff;
         end
         r.valid = s.valid || (r.ticks >= ST);
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [W-1:0] act,
                              input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs are changed 1 time unit after a rising edge and held for the
   // given number of cycles.
   task automatic applyStimulus(input logic [W-1:0] raw, input logic [W-1:0] clr,
                                input int cycles);
      sw_raw     = raw;
      edge_clear = clr;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset(input int cycles);
      reset = 1'b1;
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic clearPulseCounts();
      for (int i = 0; i < W; i++) pulse_cnt[i] = 0;
      full_change_cnt = 0;
   endtask

   task automatic waitCleanBit(input int idx, input logic val, input int budget,
                               input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         if (sw_clean[idx] === val) break;
         @(posedge clk);
         #1;
      end
      tests++;
      if (sw_clean[idx] !== val) begin
         fails++;
         $display("[TB] FAIL %s: sw_clean[%0d]=%b, expected %b within %0d cycles",
                  name, idx, sw_clean[idx], val, budget);
      end
   endtask

   // Reference model: advances on every rising edge and queues an expected
   // event whenever bits flip or sw_valid first rises.
   initial begin
      logic [W-1:0] samp;
      logic         was_valid;
      cycle = 0;
      armed = 1'b0;
      ms.n = 0; ms.ticks = 0; ms.hist = '0; ms.nhist = 0;
      ms.clean = '0; ms.change = '0; ms.cap = '0; ms.valid = 1'b0;
      forever begin
         @(posedge clk);
         cycle = cycle + 1;
         samp = (ms.n >= 2 && raw_log.size() >= 2) ? raw_log[raw_log.size()-2] : '0;
         was_valid = ms.valid;
         ms = modelStep(ms, reset, samp, edge_clear);
         if (reset === 1'b1) begin
            armed = 1'b1;
         end else if (ms.change != '0 || (ms.valid && !was_valid)) begin
            exp_q.push_back('{cyc: cycle, clean: ms.clean, change: ms.change,
                              valid: ms.valid});
         end
         raw_log.push_back(sw_raw);
         if (raw_log.size() > 4) void'(raw_log.pop_front());
      end
   end

   // Monitor: compares steady state every falling edge and pops the
   // scoreboard whenever the DUT presents a change pulse or a valid rise.
   initial begin
      logic prev_valid;
      exp_t rec;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (armed) begin
            checkOutput("clean", sw_clean, ms.clean);
            checkOutput("change", sw_change, ms.change);
            checkOutput("valid", W'(sw_valid), W'(ms.valid));
            checkOutput("capture", edge_capture, ms.cap);
            if (sw_change !== '0 || (sw_valid === 1'b1 && prev_valid !== 1'b1)) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("[TB] FAIL event: unexpected change=%h valid=%b, expected no event",
                           sw_change, sw_valid);
               end else begin
                  rec = exp_q.pop_front();
                  checkCount("event_cycle", cycle, rec.cyc);
                  checkOutput("event_clean", sw_clean, rec.clean);
                  checkOutput("event_change", sw_change, rec.change);
               end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cycle) begin
               rec = exp_q.pop_front();
               tests++;
               fails++;
               $display("[TB] FAIL missed_event: got none, expected change=%h at cycle %0d",
                        rec.change, rec.cyc);
            end
            for (int i = 0; i < W; i++) begin
               if (sw_change[i] === 1'b1) pulse_cnt[i]++;
            end
            if (sw_change === '1) full_change_cnt++;
            prev_valid = sw_valid;
         end
      end
   end

   // Directed scenarios from the plan, then randomized traffic.
   initial begin
      logic [W-1:0] raw;
      logic [W-1:0] clr;
      int           k;
      tests  = 0;
      fails  = 0;
      reset  = 1'b1;
      sw_raw = 18'h00005;
      edge_clear = '0;
      clearPulseCounts();

      // Switches held through reset: appear together with sw_valid.
      doReset(2);
      checkOutput("reset_clean", sw_clean, '0);
      checkOutput("reset_valid", W'(sw_valid), '0);
      applyStimulus(18'h00005, '0, 11);
      checkOutput("s1_valid_early", W'(sw_valid), '0);
      checkOutput("s1_clean_early", sw_clean, '0);
      applyStimulus(18'h00005, '0, 1);
      checkOutput("s1_clean", sw_clean, 18'h00005);
      checkOutput("s1_valid", W'(sw_valid), 18'h1);
      applyStimulus(18'h00005, '0, 3);
      checkCount("s1_pulse0", pulse_cnt[0], 1);
      checkCount("s1_pulse2", pulse_cnt[2], 1);
      checkCount("s1_pulse1", pulse_cnt[1], 0);

      // Bounce on bit 3, then a clean hold.
      clearPulseCounts();
      for (int t = 0; t < 14; t++) begin
         applyStimulus((t % 2 == 0) ? 18'h0000D : 18'h00005, '0, 3);
      end
      checkOutput("s2_bounce_clean", sw_clean, 18'h00005);
      checkCount("s2_bounce_pulses", pulse_cnt[3], 0);
      applyStimulus(18'h0000D, '0, 0);
      waitCleanBit(3, 1'b1, 2 + TD + ST * TD + 2, "s2_rise");
      applyStimulus(18'h0000D, '0, 3);
      checkCount("s2_pulse3", pulse_cnt[3], 1);

      // All bits rise on the same tick.
      sw_raw = '0;
      doReset(1);
      applyStimulus('0, '0, 20);
      clearPulseCounts();
      applyStimulus('1, '0, 20);
      checkOutput("s3_clean", sw_clean, '1);
      checkCount("s3_full_pulse", full_change_cnt, 1);

      // Reset in the middle of a bit 7 debounce.
      sw_raw = '0;
      doReset(1);
      applyStimulus(18'h00080, '0, 9);
      doReset(1);
      checkOutput("s4_clean_after_reset", sw_clean, '0);
      checkOutput("s4_valid_after_reset", W'(sw_valid), '0);
      applyStimulus(18'h00080, '0, 11);
      checkOutput("s4_clean_before", sw_clean, '0);
      applyStimulus(18'h00080, '0, 1);
      checkOutput("s4_clean_after", sw_clean, 18'h00080);

      // Edge capture on bit 1: set, clear, then set racing a clear.
      applyStimulus(18'h00082, '0, 20);
      checkOutput("s5_set", edge_capture, CAP_EN ? 18'h00002 : 18'h0);
      applyStimulus(18'h00082, 18'h00002, 1);
      checkOutput("s5_clear", edge_capture, '0);
      applyStimulus(18'h00080, '0, 20);
      checkOutput("s5_fall_nocap", edge_capture, '0);
      sw_raw     = 18'h00082;
      edge_clear = 18'h00002;
      for (k = 0; k < 30; k++) begin
         @(posedge clk);
         #1;
         if (sw_change[1] === 1'b1) break;
      end
      checkCount("s5_pulse_seen", (sw_change[1] === 1'b1) ? 1 : 0, 1);
      @(posedge clk);
      #1;
      edge_clear = '0;
      checkOutput("s5_set_wins", edge_capture, CAP_EN ? 18'h00002 : 18'h0);
      applyStimulus(18'h00082, '0, 2);
      checkOutput("s5_hold", edge_capture, CAP_EN ? 18'h00002 : 18'h0);

      // Randomized traffic with occasional resets and clears.
      raw = 18'h00082;
      for (int it = 0; it < 220; it++) begin
         if ($urandom_range(0, 40) == 0) begin
            doReset($urandom_range(1, 2));
         end
         raw = raw ^ W'($urandom & $urandom & $urandom);
         clr = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         applyStimulus(raw, clr, $urandom_range(1, 16));
      end
      applyStimulus(raw, '0, 5);
      checkCount("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
